// File: rtl/cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen
//   Synthetic camera source for bring-up of the camera capture path. It
//   produces the same pixel bus as the sensor (pclk / vsync / href / 6-bit
//   dout) from the system clock, with parameterised frame timing and
//   selectable test patterns.
//
// Ports
//   clk         system clock; all logic on its rising edge
//   reset       synchronous, active-high reset
//   enable      start frames / keep running back-to-back frames
//   mode[1:0]   pattern select (0 ramp, 1 bars, 2 fixed, 3 line index),
//               latched at frame start
//   fixed_val   constant pattern value for mode 2, latched at frame start
//   pclk        pixel clock (registered)
//   vsync       high during the sync lines
//   href        high during active pixels of active lines
//   dout[5:0]   pixel data, 0 whenever href is low
//   busy        high from frame start until the frame ends
//   frame_done  one-clk pulse in the cycle after the last cycle of a frame
// -----------------------------------------------------------------------------
module cam_pattern_gen #(
    parameter int H_ACTIVE = 16,
    parameter int H_BLANK  = 4,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 2,
    parameter int V_ACTIVE = 12,
    parameter int V_FRONT  = 2,
    parameter int PCLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [5:0] fixed_val,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [5:0] dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int CW      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_BACK,
        S_ACTIVE,
        S_FRONT
    } state_t;

    // Registered state
    state_t          r_state;
    logic [CW-1:0]   r_div;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_line;
    logic [1:0]      r_mode;
    logic [5:0]      r_fixed;
    logic            r_pclk;
    logic            r_vsync;
    logic            r_href;
    logic [5:0]      r_dout;
    logic            r_busy;
    logic            r_frame_done;

    // Next-state values
    state_t          w_state_next;
    logic [CW-1:0]   w_div_next;
    logic [CW-1:0]   w_x_next;
    logic [CW-1:0]   w_line_next;
    logic [1:0]      w_mode_next;
    logic [5:0]      w_fixed_next;
    logic            w_frame_end;
    logic [CW-1:0]   w_line_last;
    logic            w_div_wrap;
    logic            w_x_wrap;
    logic            w_line_wrap;

    // Output decode of the next state
    logic            w_pclk_next;
    logic            w_vsync_next;
    logic            w_href_next;
    logic [5:0]      w_dout_next;
    logic            w_busy_next;
    logic [5:0]      w_bars;

    assign w_div_wrap  = (r_div == CW'(PCLK_DIV - 1));
    assign w_x_wrap    = w_div_wrap && (r_x == CW'(H_TOTAL - 1));
    assign w_line_wrap = w_x_wrap && (r_line == w_line_last);

    // Bars pattern: the low three bits of x repeated in both halves.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_bars
            assign w_bars[gi] = w_x_next[gi % 3];
        end
    endgenerate

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_x          <= '0;
            r_line       <= '0;
            r_mode       <= '0;
            r_fixed      <= '0;
            r_pclk       <= 1'b0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_dout       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_x          <= w_x_next;
            r_line       <= w_line_next;
            r_mode       <= w_mode_next;
            r_fixed      <= w_fixed_next;
            r_pclk       <= w_pclk_next;
            r_vsync      <= w_vsync_next;
            r_href       <= w_href_next;
            r_dout       <= w_dout_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_end;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_x_next     = r_x;
        w_line_next  = r_line;
        w_mode_next  = r_mode;
        w_fixed_next = r_fixed;
        w_frame_end  = 1'b0;

        // Last line index of the current vertical region. Zero-line regions
        // are never entered, so their wrapped value is never used.
        case (r_state)
            S_SYNC:   w_line_last = CW'(V_SYNC - 1);
            S_BACK:   w_line_last = CW'(V_BACK - 1);
            S_ACTIVE: w_line_last = CW'(V_ACTIVE - 1);
            S_FRONT:  w_line_last = CW'(V_FRONT - 1);
            default:  w_line_last = '0;
        endcase

        if (r_state == S_IDLE) begin
            if (enable) begin
                w_state_next = S_SYNC;
                w_div_next   = '0;
                w_x_next     = '0;
                w_line_next  = '0;
                w_mode_next  = mode;
                w_fixed_next = fixed_val;
            end
        end else begin
            w_div_next = w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap) begin
                w_x_next = w_x_wrap ? '0 : r_x + 1'b1;
            end
            if (w_x_wrap) begin
                w_line_next = w_line_wrap ? '0 : r_line + 1'b1;
            end
            if (w_line_wrap) begin
                case (r_state)
                    S_SYNC:   w_state_next = (V_BACK > 0) ? S_BACK : S_ACTIVE;
                    S_BACK:   w_state_next = S_ACTIVE;
                    S_ACTIVE: begin
                        if (V_FRONT > 0) begin
                            w_state_next = S_FRONT;
                        end else begin
                            w_frame_end = 1'b1;
                        end
                    end
                    S_FRONT:  w_frame_end = 1'b1;
                    default:  w_state_next = S_IDLE;
                endcase
            end
            // All counters have wrapped to 0 here, so a back-to-back frame
            // starts with the same counter values as one started from IDLE.
            if (w_frame_end) begin
                if (enable) begin
                    w_state_next = S_SYNC;
                    w_mode_next  = mode;
                    w_fixed_next = fixed_val;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
        end
    end

    // -------------------------------------------------------------- output comb
    // Outputs are decoded from the next state and registered, so they change
    // together with the counters; vsync/href/dout therefore only move on the
    // edge where div returns to 0 (pclk falling).
    always_comb begin
        w_busy_next  = (w_state_next != S_IDLE);
        w_pclk_next  = w_busy_next && (w_div_next >= CW'(PCLK_DIV / 2));
        w_vsync_next = (w_state_next == S_SYNC);
        w_href_next  = (w_state_next == S_ACTIVE) && (w_x_next < CW'(H_ACTIVE));
        w_dout_next  = '0;
        if (w_href_next) begin
            case (w_mode_next)
                2'd0:    w_dout_next = w_x_next[5:0];
                2'd1:    w_dout_next = w_bars;
                2'd2:    w_dout_next = w_fixed_next;
                default: w_dout_next = w_line_next[5:0];
            endcase
        end
    end

    assign pclk       = r_pclk;
    assign vsync      = r_vsync;
    assign href       = r_href;
    assign dout       = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_pattern_gen.sv
module tb_cam_pattern_gen;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VA = 3;
    localparam int VF = 1;
    localparam int PD = 2;
    localparam int FRAME = 72;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [5:0] fixed_val;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [5:0] dout;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    cam_pattern_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .PCLK_DIV (PD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .fixed_val  (fixed_val),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc;
    int fd_cyc;
    int n_vsync, n_href, n_fd, n_bursts, n_vs_rise, n_nonzero;
    bit ok;

    logic [5:0] exp_q[$];
    logic       prev_pclk  = 1'b0;
    logic       prev_href  = 1'b0;
    logic       prev_vsync = 1'b0;
    logic [5:0] prev_dout  = 6'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        n_vsync   = 0;
        n_href    = 0;
        n_fd      = 0;
        n_bursts  = 0;
        n_vs_rise = 0;
        n_nonzero = 0;
        fd_cyc    = -1;
    endtask

    // Expected pixel values, in order, for one full frame of a given mode.
    task automatic push_frame(input logic [1:0] m, input logic [5:0] fv);
        logic [5:0] bars[4];
        bars = '{6'h00, 6'h09, 6'h12, 6'h1B};
        for (int l = 0; l < VA; l++) begin
            for (int x = 0; x < HA; x++) begin
                case (m)
                    2'd0:    exp_q.push_back(6'(x));
                    2'd1:    exp_q.push_back(bars[x]);
                    2'd2:    exp_q.push_back(fv);
                    default: exp_q.push_back(6'(l));
                endcase
            end
        end
    endtask

    // One clk cycle: advance, sample 1 time unit after the edge, gather
    // statistics and check pixels on pclk rises against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (vsync) n_vsync++;
        if (href) n_href++;
        if (frame_done) begin
            n_fd++;
            fd_cyc = cyc;
        end
        if (href && !prev_href) n_bursts++;
        if (vsync && !prev_vsync) n_vs_rise++;
        if ({pclk, vsync, href, dout, busy, frame_done} != 11'd0) n_nonzero++;
        if (!href) check("dout_blank", 32'(dout), 32'd0);
        if (pclk && !prev_pclk) begin
            check("stable_at_rise", 32'({vsync, href, dout}),
                  32'({prev_vsync, prev_href, prev_dout}));
            if (href) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=%0h expected=queued_pixel", dout);
                end
                if (exp_q.size() > 0) check("dout_pixel", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        prev_pclk  = pclk;
        prev_href  = href;
        prev_vsync = vsync;
        prev_dout  = dout;
    endtask

    task automatic wait_fd(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("fd_seen", 32'(found), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        mode      = 2'd0;
        fixed_val = 6'd0;
        clear_stats();
        repeat (3) tick();
        check("rst_outputs", 32'({pclk, vsync, href, dout, busy, frame_done}), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_outputs", 32'({pclk, vsync, href, dout, busy, frame_done}), 32'd0);

        // 1: single frame, horizontal ramp
        clear_stats();
        mode = 2'd0;
        push_frame(2'd0, 6'd0);
        enable = 1'b1;
        tick();
        start_cyc = cyc;
        enable = 1'b0;
        check("s1_start_vsync", 32'(vsync), 32'd1);
        check("s1_start_busy", 32'(busy), 32'd1);
        check("s1_start_pclk", 32'(pclk), 32'd0);
        tick();
        check("s1_pclk_high", 32'(pclk), 32'd1);
        wait_fd(200, ok);
        check("s1_fd_latency", 32'(fd_cyc - start_cyc), 32'(FRAME));
        check("s1_busy_fall", 32'(busy), 32'd0);
        check("s1_vsync_cycles", 32'(n_vsync), 32'd12);
        check("s1_href_cycles", 32'(n_href), 32'd24);
        check("s1_href_bursts", 32'(n_bursts), 32'd3);
        check("s1_fd_count", 32'(n_fd), 32'd1);
        check("s1_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("s1_fd_one_cycle", 32'(frame_done), 32'd0);

        // 2: back-to-back frames, line index pattern
        clear_stats();
        mode = 2'd3;
        push_frame(2'd3, 6'd0);
        push_frame(2'd3, 6'd0);
        enable = 1'b1;
        tick();
        start_cyc = cyc;
        wait_fd(200, ok);
        check("s2_fd1_latency", 32'(fd_cyc - start_cyc), 32'(FRAME));
        check("s2_b2b_vsync", 32'(vsync), 32'd1);
        check("s2_b2b_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_fd(200, ok);
        check("s2_fd2_latency", 32'(fd_cyc - start_cyc), 32'(2 * FRAME));
        check("s2_busy_fall", 32'(busy), 32'd0);
        check("s2_vsync_rises", 32'(n_vs_rise), 32'd2);
        check("s2_fd_count", 32'(n_fd), 32'd2);
        check("s2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: fixed value, mode changed mid-frame
        clear_stats();
        mode      = 2'd2;
        fixed_val = 6'h2A;
        push_frame(2'd2, 6'h2A);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (40) tick();
        mode      = 2'd0;
        fixed_val = 6'h00;
        wait_fd(200, ok);
        check("s3_fd_count", 32'(n_fd), 32'd1);
        check("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: bars
        clear_stats();
        mode = 2'd1;
        push_frame(2'd1, 6'd0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_fd(200, ok);
        check("s4_href_cycles", 32'(n_href), 32'd24);
        check("s4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of the second active line
        clear_stats();
        mode = 2'd0;
        push_frame(2'd0, 6'd0);
        enable = 1'b1;
        tick();
        start_cyc = cyc;
        enable = 1'b0;
        repeat (39) tick();
        check("s5_in_line2_href", 32'(href), 32'd1);
        reset = 1'b1;
        tick();
        check("s5_reset_outputs", 32'({pclk, vsync, href, dout, busy, frame_done}), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        clear_stats();
        repeat (30) tick();
        check("s5_stay_idle", 32'(n_nonzero), 32'd0);

        // 6: enable dropped during the first frame
        clear_stats();
        mode = 2'd0;
        push_frame(2'd0, 6'd0);
        enable = 1'b1;
        tick();
        start_cyc = cyc;
        repeat (20) tick();
        enable = 1'b0;
        wait_fd(200, ok);
        check("s6_fd_latency", 32'(fd_cyc - start_cyc), 32'(FRAME));
        check("s6_busy_fall", 32'(busy), 32'd0);
        check("s6_fd_count", 32'(n_fd), 32'd1);
        check("s6_sb_empty", 32'(exp_q.size()), 32'd0);
        clear_stats();
        repeat (100) tick();
        check("s6_no_vsync", 32'(n_vsync), 32'd0);
        check("s6_stay_idle", 32'(n_nonzero), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
